// File: rtl/digit_render.sv
// ---------------------------------------------------------------------------
// digit_render
//   Minutes:seconds timer (0:00 .. 9:59) rendered as three seven-segment
//   digits on a raster display. A prescaler divides the pixel clock to a
//   one-second tick. The time digits are snapshotted at pixel (0,0) of each
//   frame, so a frame never shows two different times.
//
// Ports
//   clk_sel    in   1   pixel clock, rising edge
//   rst_sel    in   1   asynchronous active-high reset
//   h_index    in  10   current pixel column
//   v_index    in  10   current pixel row
//   sel_digit  in   2   cell select from upstream, one cycle behind the
//                       indices (00 none, 01 sec, 10 ten-sec, 11 min)
//   run        in   1   1 = timer counts, 0 = timer and prescaler frozen
//   clear      in   1   synchronous clear of prescaler and all digits
//   pixel_on   out  1   registered, current pixel is a lit segment
//   wrap       out  1   registered one-cycle pulse on 9:59 -> 0:00
// ---------------------------------------------------------------------------
module digit_render #(
   parameter int TICK_DIV = 25000000,
   parameter int SEC_X    = 250,
   parameter int TEN_X    = 320,
   parameter int MIN_X    = 450,
   parameter int TOP_Y    = 50
) (
   input  logic       clk_sel,
   input  logic       rst_sel,
   input  logic [9:0] h_index,
   input  logic [9:0] v_index,
   input  logic [1:0] sel_digit,
   input  logic       run,
   input  logic       clear,
   output logic       pixel_on,
   output logic       wrap
);

   localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic [3:0]    sec_q, sec_d;
   logic [2:0]    ten_q, ten_d;
   logic [3:0]    min_q, min_d;
   logic          wrap_q, wrap_d;
   logic [3:0]    disp_sec_q;
   logic [2:0]    disp_ten_q;
   logic [3:0]    disp_min_q;
   // Indices delayed one cycle so they line up with sel_digit.
   logic [9:0]    h_q, v_q;
   logic          pixel_q, pixel_d;
   logic          tick;
   logic          snap;

   assign tick = run && (pre_q == PRE_MAX);
   assign snap = (h_q == 10'd0) && (v_q == 10'd0);

   // Timer next state. clear wins over everything, including a tick in the
   // same cycle, and never produces a wrap pulse.
   always_comb begin
      pre_d  = pre_q;
      sec_d  = sec_q;
      ten_d  = ten_q;
      min_d  = min_q;
      wrap_d = 1'b0;
      if (clear) begin
         pre_d = '0;
         sec_d = 4'd0;
         ten_d = 3'd0;
         min_d = 4'd0;
      end else if (run) begin
         if (tick) begin
            pre_d = '0;
            if (sec_q == 4'd9) begin
               sec_d = 4'd0;
               if (ten_q == 3'd5) begin
                  ten_d = 3'd0;
                  if (min_q == 4'd9) begin
                     min_d  = 4'd0;
                     wrap_d = 1'b1;
                  end else begin
                     min_d = min_q + 4'd1;
                  end
               end else begin
                  ten_d = ten_q + 3'd1;
               end
            end else begin
               sec_d = sec_q + 4'd1;
            end
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   // Segment pattern, bit order {a,b,c,d,e,f,g}.
   function automatic logic [6:0] seg_map(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // Pixel rendering from the snapshot values only.
   logic [9:0] base, x, y;
   logic [3:0] val;
   logic       en;
   logic [6:0] seg;
   logic       in_cell, x_mid, x_left, x_right, y_top, y_up, y_low, y_bot, y_mid;

   always_comb begin
      base = 10'(SEC_X);
      val  = disp_sec_q;
      en   = 1'b0;
      case (sel_digit)
         2'b01: begin base = 10'(SEC_X); val = disp_sec_q;        en = 1'b1; end
         2'b10: begin base = 10'(TEN_X); val = {1'b0, disp_ten_q}; en = 1'b1; end
         2'b11: begin base = 10'(MIN_X); val = disp_min_q;        en = 1'b1; end
         default: ;
      endcase
      // Unsigned 10-bit subtraction: a pixel left of/above the cell wraps to
      // a large value and falls out of the 0..31 window.
      x       = h_q - base;
      y       = v_q - 10'(TOP_Y);
      in_cell = (x < 10'd32) && (y < 10'd32);
      seg     = seg_map(val);
      x_left  = (x <= 10'd3);
      x_mid   = (x >= 10'd4)  && (x <= 10'd27);
      x_right = (x >= 10'd28) && (x <= 10'd31);
      y_top   = (y <= 10'd3);
      y_up    = (y >= 10'd4)  && (y <= 10'd15);
      y_low   = (y >= 10'd16) && (y <= 10'd27);
      y_bot   = (y >= 10'd28) && (y <= 10'd31);
      y_mid   = (y >= 10'd14) && (y <= 10'd17);
      pixel_d = en && in_cell &&
                ((seg[6] && y_top   && x_mid) ||
                 (seg[5] && x_right && y_up ) ||
                 (seg[4] && x_right && y_low) ||
                 (seg[3] && y_bot   && x_mid) ||
                 (seg[2] && x_left  && y_low) ||
                 (seg[1] && x_left  && y_up ) ||
                 (seg[0] && y_mid   && x_mid));
   end

   always_ff @(posedge clk_sel or posedge rst_sel) begin
      if (rst_sel) begin
         pre_q      <= '0;
         sec_q      <= 4'd0;
         ten_q      <= 3'd0;
         min_q      <= 4'd0;
         wrap_q     <= 1'b0;
         disp_sec_q <= 4'd0;
         disp_ten_q <= 3'd0;
         disp_min_q <= 4'd0;
         h_q        <= 10'd0;
         v_q        <= 10'd0;
         pixel_q    <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         sec_q   <= sec_d;
         ten_q   <= ten_d;
         min_q   <= min_d;
         wrap_q  <= wrap_d;
         h_q     <= h_index;
         v_q     <= v_index;
         pixel_q <= pixel_d;
         if (snap) begin
            disp_sec_q <= sec_q;
            disp_ten_q <= ten_q;
            disp_min_q <= min_q;
         end
      end
   end

   assign pixel_on = pixel_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_digit_render.sv
// ---------------------------------------------------------------------------
// tb_digit_render
//   Directed bench for digit_render with TICK_DIV=4. Stimulus pushes expected
//   pixel values into exp_q (checked two cycles later when the marker
//   pipeline reaches the output) and state expectations into chk_q (checked
//   at the next falling edge). A single monitor process does all comparing.
// ---------------------------------------------------------------------------
module tb_digit_render;

   localparam int K_DIG      = 0;  // {min,ten,sec}
   localparam int K_PRE      = 1;
   localparam int K_WRAP_NOW = 2;
   localparam int K_WRAP_CNT = 3;
   localparam int K_PIXNOW   = 4;

   typedef struct {
      int          kind;
      logic [15:0] exp;
   } chk_t;

   logic       clk_sel = 1'b0;
   logic       rst_sel = 1'b1;
   logic [9:0] h_index = 10'd1023;
   logic [9:0] v_index = 10'd1023;
   logic [1:0] sel_digit = 2'b00;
   logic       run = 1'b0;
   logic       clear = 1'b0;
   logic       pixel_on;
   logic       wrap;

   logic [0:0] exp_q[$];
   chk_t       chk_q[$];
   logic       mark_in = 1'b0;
   logic       mark_d1 = 1'b0;
   logic       mark_d2 = 1'b0;
   logic       ending = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         wrap_cnt = 0;
   logic       prev_wrap = 1'b0;

   digit_render #(.TICK_DIV(4)) dut (
      .clk_sel   (clk_sel),
      .rst_sel   (rst_sel),
      .h_index   (h_index),
      .v_index   (v_index),
      .sel_digit (sel_digit),
      .run       (run),
      .clear     (clear),
      .pixel_on  (pixel_on),
      .wrap      (wrap)
   );

   // ---------------- clock ----------------
   initial forever #5 clk_sel = ~clk_sel;

   always @(posedge clk_sel) begin
      mark_d1 <= mark_in;
      mark_d2 <= mark_d1;
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk_sel) begin
      chk_t        c;
      logic [15:0] act;
      if (wrap) begin
         n_checks++;
         if (prev_wrap) begin
            n_fail++;
            $display("FAIL wrap_double: wrap high two cycles in a row (got 1, want 0 on second)");
         end
         wrap_cnt++;
      end
      prev_wrap = wrap;
      if (mark_d2) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pix_underflow: pixel marker with empty exp_q");
         end else begin
            logic [0:0] e;
            e = exp_q.pop_front();
            if (pixel_on !== e[0]) begin
               n_fail++;
               $display("FAIL pixel @%0t: got %b want %b", $time, pixel_on, e[0]);
            end
         end
      end
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         case (c.kind)
            K_DIG:      act = 16'({dut.min_q, dut.ten_q, dut.sec_q});
            K_PRE:      act = 16'(dut.pre_q);
            K_WRAP_NOW: act = 16'(wrap);
            K_WRAP_CNT: act = 16'(wrap_cnt);
            default:    act = 16'(pixel_on);
         endcase
         n_checks++;
         if (act !== c.exp) begin
            n_fail++;
            $display("FAIL chk_kind%0d @%0t: got 0x%0h want 0x%0h", c.kind, $time, act, c.exp);
         end
      end
      if (ending && exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL pix_leftover: %0d expected pixels never observed", exp_q.size());
         exp_q.delete();
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk_sel);
      #1;
   endtask

   task automatic push(input int kind, input logic [15:0] exp);
      chk_t c;
      c.kind = kind;
      c.exp  = exp;
      chk_q.push_back(c);
   endtask

   function automatic logic [15:0] dig(input int m, input int t, input int s);
      logic [3:0] mm, ss;
      logic [2:0] tt;
      mm = 4'(m);
      tt = 3'(t);
      ss = 4'(s);
      return 16'({mm, tt, ss});
   endfunction

   task automatic render(input int h, input int v, input logic [1:0] s, input logic e);
      cyc(1);
      h_index   = 10'(h);
      v_index   = 10'(v);
      sel_digit = 2'b00;
      mark_in   = 1'b1;
      exp_q.push_back(e);
      cyc(1);
      mark_in   = 1'b0;
      sel_digit = s;
      h_index   = 10'd1023;
      v_index   = 10'd1023;
      cyc(1);
      sel_digit = 2'b00;
   endtask

   task automatic snapshot();
      cyc(1);
      h_index = 10'd0;
      v_index = 10'd0;
      cyc(1);
      h_index = 10'd1023;
      v_index = 10'd1023;
      cyc(1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      cyc(2);
      push(K_DIG, dig(0, 0, 0));
      push(K_PRE, 16'd0);
      push(K_PIXNOW, 16'd0);
      push(K_WRAP_NOW, 16'd0);
      rst_sel = 1'b0;
      cyc(1);

      // 40 cycles of run -> 10 ticks -> 0:10
      run = 1'b1;
      cyc(40);
      run = 1'b0;
      push(K_DIG, dig(0, 1, 0));
      push(K_PRE, 16'd0);
      push(K_WRAP_CNT, 16'd0);

      // advance to sec=3 with prescaler at its last count, then clear
      run = 1'b1;
      cyc(15);
      push(K_DIG, dig(0, 1, 3));
      push(K_PRE, 16'd3);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      run   = 1'b0;
      push(K_DIG, dig(0, 0, 0));
      push(K_PRE, 16'd0);
      push(K_WRAP_NOW, 16'd0);

      // 599 ticks -> 9:59, then one more tick wraps
      run = 1'b1;
      cyc(599 * 4);
      push(K_DIG, dig(9, 5, 9));
      push(K_WRAP_CNT, 16'd0);
      cyc(4);
      push(K_WRAP_NOW, 16'd1);
      push(K_DIG, dig(0, 0, 0));
      cyc(1);
      run = 1'b0;
      push(K_WRAP_NOW, 16'd0);
      push(K_WRAP_CNT, 16'd1);

      // reset mid-count discards partial prescaler progress
      run = 1'b1;
      cyc(1);
      rst_sel = 1'b1;
      push(K_PRE, 16'd0);
      cyc(1);
      rst_sel = 1'b0;
      cyc(3);
      push(K_DIG, dig(0, 0, 0));
      push(K_PRE, 16'd3);
      cyc(1);
      run = 1'b0;
      push(K_DIG, dig(0, 0, 1));

      // render: snapshot sec=1, ten=0, min=0
      snapshot();
      render(280, 60, 2'b01, 1'b1);  // b of "1"
      render(252, 60, 2'b01, 1'b0);  // f not in "1"
      render(280, 60, 2'b00, 1'b0);  // no cell selected
      render(282, 60, 2'b01, 1'b0);  // x = 32, outside cell
      render(249, 60, 2'b01, 1'b0);  // x = -1, outside cell
      render(252, 52, 2'b01, 1'b0);  // corner gap
      render(322, 60, 2'b10, 1'b1);  // f of "0"
      render(330, 66, 2'b10, 1'b0);  // g not in "0"
      render(460, 51, 2'b11, 1'b1);  // a of "0"
      render(280, 70, 2'b01, 1'b1);  // c of "1"

      // count to sec=2 without a snapshot: display must hold "1"
      run = 1'b1;
      cyc(4);
      run = 1'b0;
      push(K_DIG, dig(0, 0, 2));
      render(280, 70, 2'b01, 1'b1);
      snapshot();
      render(280, 70, 2'b01, 1'b0);  // c not in "2"
      render(252, 70, 2'b01, 1'b1);  // e of "2"

      // hold a lit pixel, then assert reset between clock edges
      h_index = 10'd252;
      v_index = 10'd70;
      cyc(1);
      sel_digit = 2'b01;
      cyc(2);
      push(K_PIXNOW, 16'd1);
      cyc(1);
      rst_sel = 1'b1;
      push(K_PIXNOW, 16'd0);
      push(K_DIG, dig(0, 0, 0));
      push(K_PRE, 16'd0);
      push(K_WRAP_NOW, 16'd0);
      cyc(2);
      rst_sel   = 1'b0;
      sel_digit = 2'b00;
      h_index   = 10'd1023;
      v_index   = 10'd1023;
      push(K_WRAP_CNT, 16'd1);
      cyc(2);

      ending = 1'b1;
      @(negedge clk_sel);
      @(negedge clk_sel);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/digit_render.md
DIGIT_RENDER -- requirements
Module: digit_render

Interface
REQ-001 Parameters: TICK_DIV, default 25000000, clk_sel cycles per one-second tick.
REQ-002 Parameters: SEC_X / TEN_X / MIN_X, defaults 250 / 320 / 450, left column of each digit cell; TOP_Y, default 50, top row of all cells.
REQ-003 Ports: clk_sel  input  1  pixel clock; all logic on rising edge.
REQ-004 Ports: rst_sel  input  1  reset, asynchronous, active-high.
REQ-005 Ports: h_index  input  10  current pixel column, same cycle as fed to the upstream selector.
REQ-006 Ports: v_index  input  10  current pixel row, same cycle as fed to the upstream selector.
REQ-007 Ports: sel_digit  input  2  registered cell select from upstream, 1 cycle behind h_index/v_index: 00 none, 01 seconds, 10 ten-seconds, 11 minutes.
REQ-008 Ports: run  input  1  level; 1 = timer counts, 0 = timer and prescaler frozen.
REQ-009 Ports: clear  input  1  synchronous clear of prescaler and all time digits.
REQ-010 Ports: pixel_on  output  1  registered; 1 = current pixel is a lit digit segment.
REQ-011 Ports: wrap  output  1  registered one-cycle pulse when time rolls 9:59 -> 0:00.

Function
REQ-012 Registered copies h_d/v_d of h_index/v_index (1 cycle), aligned with sel_digit.
REQ-013 Prescaler counts 0..TICK_DIV-1 while run=1; tick asserted in the cycle it equals TICK_DIV-1, then reloads 0.
REQ-014 On tick: sec +1; sec 9 -> 0 carries into ten_sec; ten_sec 5 -> 0 carries into min; min 9 -> 0 with sec and ten_sec wrapping asserts wrap next cycle.
REQ-015 Digit widths: sec 4 bits (0..9), ten_sec 3 bits (0..5), min 4 bits (0..9); no other values ever held.
REQ-016 clear=1 zeroes prescaler and all digits next edge, overrides tick and run in the same cycle; wrap not asserted by clear.
REQ-017 Display snapshot: sec/ten_sec/min copied into disp_sec/disp_ten/disp_min when h_d==0 and v_d==0; rendering uses only snapshot values (no mid-frame tearing).
REQ-018 Cell selection: value and base column by sel_digit (01 disp_sec/SEC_X, 10 disp_ten/TEN_X, 11 disp_min/MIN_X); 00 -> pixel_on 0 next cycle.
REQ-019 Cell coordinates x = h_d - base, y = v_d - TOP_Y, 10-bit; if x or y outside 0..31, pixel off.
REQ-020 Segments in the 32x32 cell: a y0..3,x4..27; b x28..31,y4..15; c x28..31,y16..27; d y28..31,x4..27; e x0..3,y16..27; f x0..3,y4..15; g y14..17,x4..27.
REQ-021 Segment map: 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc; 8 abcdefg; 9 abcdfg.
REQ-022 pixel_on registered from REQ-018..021: total latency 2 cycles from h_index/v_index, 1 cycle from sel_digit.
REQ-023 wrap high exactly one cycle per rollover; never two consecutive cycles.

Reset
REQ-024 rst_sel=1 forces immediately: prescaler, sec, ten_sec, min, snapshots, h_d, v_d = 0; pixel_on = 0; wrap = 0.
REQ-025 Reset mid-count discards partial prescaler progress; first tick after release occurs TICK_DIV cycles after the first run=1 edge.

Verification (bench TICK_DIV=4, defaults otherwise)
REQ-026 Reset, run=1 for 40 cycles -> 10 ticks; sec=0, ten_sec=1, min=0; wrap never set.
REQ-027 Preload to 9:59 via counting (599 ticks), one more tick -> all digits 0, wrap=1 exactly one cycle.
REQ-028 clear=1 in the same cycle as a tick at sec=3 -> sec=0, prescaler=0, no increment, wrap=0.
REQ-029 disp_sec=1, h_index=280, v_index=60, sel_digit=01 one cycle later -> pixel_on=1 two cycles after index (segment b); h_index=252 same row -> pixel_on=0.
REQ-030 sel_digit=00 with any index -> pixel_on=0; digit change mid-frame -> pixel_on unchanged until next h_d=v_d=0 snapshot.
REQ-031 Assert rst_sel mid-frame with pixel_on=1 -> pixel_on=0 and all digits 0 without a clock edge.
